// File: rtl/sdes_pkg.sv
// Shared S-DES definitions: FSM states, permutation tables, S-boxes and the
// bit-shuffling helpers used by the core and its round function.
package sdes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KEYGEN,
        ROUND1,
        ROUND2,
        DONE
    } state_t;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Each table packs 4-bit source positions left to right (position 1 = MSB),
    // zero-padded to ten entries so one permute helper serves every width.
    localparam logic [39:0] P10_TBL   = {4'd3, 4'd5, 4'd2, 4'd7, 4'd4, 4'd10, 4'd1, 4'd9, 4'd8, 4'd6};
    localparam logic [39:0] P8_TBL    = {4'd6, 4'd3, 4'd7, 4'd4, 4'd8, 4'd5, 4'd10, 4'd9, 8'h00};
    localparam logic [39:0] IP_TBL    = {4'd2, 4'd6, 4'd3, 4'd1, 4'd4, 4'd8, 4'd5, 4'd7, 8'h00};
    localparam logic [39:0] IPINV_TBL = {4'd4, 4'd1, 4'd3, 4'd5, 4'd7, 4'd2, 4'd8, 4'd6, 8'h00};
    localparam logic [39:0] EP_TBL    = {4'd4, 4'd1, 4'd2, 4'd3, 4'd2, 4'd3, 4'd4, 4'd1, 8'h00};
    localparam logic [39:0] P4_TBL    = {4'd2, 4'd4, 4'd3, 4'd1, 24'h000000};

    // S-boxes indexed by {row, col}, row = nibble bits 1 and 4, col = bits 2 and 3.
    localparam logic [1:0] S0_BOX [16] = '{
        2'd1, 2'd0, 2'd3, 2'd2,
        2'd3, 2'd2, 2'd1, 2'd0,
        2'd0, 2'd2, 2'd1, 2'd3,
        2'd3, 2'd1, 2'd3, 2'd2
    };
    localparam logic [1:0] S1_BOX [16] = '{
        2'd0, 2'd1, 2'd2, 2'd3,
        2'd2, 2'd0, 2'd1, 2'd3,
        2'd3, 2'd0, 2'd1, 2'd0,
        2'd2, 2'd1, 2'd0, 2'd3
    };

    function automatic logic [4:0] rol5(input logic [4:0] value);
        return {value[3:0], value[4]};
    endfunction

    // Result occupies bits [out_w-1:0]; src holds a src_w-bit vector in its low bits.
    function automatic logic [9:0] permute(input logic [9:0]  src,
                                           input int          src_w,
                                           input int          out_w,
                                           input logic [39:0] tbl);
        logic [9:0] res;
        logic [3:0] pos;
        res = '0;
        for (int i = 0; i < 10; i++) begin
            if (i < out_w) begin
                pos = tbl[6'(39 - 4 * i) -: 4];
                res[4'(out_w - 1 - i)] = src[4'(src_w - int'(pos))];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sdes_fk.sv
// Combinational S-DES round function fk plus the two S-box lookups it feeds.
// Output is {L ^ f, R}; the half swap between rounds is left to the caller.
module switch_s0
    import sdes_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [1:0] value
);
    assign value = S0_BOX[{nibble[3], nibble[0], nibble[2], nibble[1]}];
endmodule

module switch_s1
    import sdes_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [1:0] value
);
    assign value = S1_BOX[{nibble[3], nibble[0], nibble[2], nibble[1]}];
endmodule

module sdes_fk
    import sdes_pkg::*;
(
    input  logic [7:0] data,
    input  logic [7:0] subkey,
    output logic [7:0] result
);
    logic [7:0] mixed;
    logic [1:0] s0_value;
    logic [1:0] s1_value;
    logic [3:0] f;

    always_comb begin
        mixed = 8'(permute({6'b000000, data[3:0]}, 4, 8, EP_TBL)) ^ subkey;
    end

    switch_s0 u_s0 (
        .nibble (mixed[7:4]),
        .value  (s0_value)
    );

    switch_s1 u_s1 (
        .nibble (mixed[3:0]),
        .value  (s1_value)
    );

    always_comb begin
        f      = 4'(permute({6'b000000, s0_value, s1_value}, 4, 4, P4_TBL));
        result = {data[7:4] ^ f, data[3:0]};
    end

endmodule

// File: rtl/sdes_core.sv
// Iterative S-DES engine: accept, derive subkeys, two time-shared Feistel
// rounds, then hold the result until the downstream handshake.
module sdes_core
    import sdes_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic       i_mode,
    input  logic [9:0] i_key,
    input  logic [7:0] i_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic [7:0] o_data
);
    state_t     state;
    logic [7:0] block;
    logic [9:0] key_reg;
    logic       mode_reg;
    logic [7:0] k1;
    logic [7:0] k2;

    logic [9:0] p10;
    logic [9:0] ls1;
    logic [9:0] ls3;
    logic [7:0] k1_next;
    logic [7:0] k2_next;
    logic [7:0] ip_in;
    logic [7:0] round_key;
    logic [7:0] fk_out;
    logic [7:0] result_next;

    always_comb begin
        p10     = permute(key_reg, 10, 10, P10_TBL);
        ls1     = {rol5(p10[9:5]), rol5(p10[4:0])};
        ls3     = {rol5(rol5(ls1[9:5])), rol5(rol5(ls1[4:0]))};
        k1_next = 8'(permute(ls1, 10, 8, P8_TBL));
        k2_next = 8'(permute(ls3, 10, 8, P8_TBL));
        ip_in   = 8'(permute({2'b00, i_data}, 8, 8, IP_TBL));
        // Decrypt walks the schedule backwards: K2 in round 1, K1 in round 2.
        if ((state == ROUND1) == (mode_reg == MODE_DEC)) begin
            round_key = k2;
        end else begin
            round_key = k1;
        end
        result_next = 8'(permute({2'b00, fk_out}, 8, 8, IPINV_TBL));
    end

    sdes_fk u_fk (
        .data   (block),
        .subkey (round_key),
        .result (fk_out)
    );

    assign o_ready = (state == IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            block    <= '0;
            key_reg  <= '0;
            mode_reg <= MODE_ENC;
            k1       <= '0;
            k2       <= '0;
            o_valid  <= 1'b0;
            o_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        block    <= ip_in;
                        key_reg  <= i_key;
                        mode_reg <= i_mode;
                        state    <= KEYGEN;
                    end
                end
                KEYGEN: begin
                    k1    <= k1_next;
                    k2    <= k2_next;
                    state <= ROUND1;
                end
                ROUND1: begin
                    block <= {fk_out[3:0], fk_out[7:4]};
                    state <= ROUND2;
                end
                ROUND2: begin
                    o_data  <= result_next;
                    o_valid <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdes_core.sv
// Directed self-checking bench for sdes_core using hand-computed S-DES vectors.
module tb_sdes_core;

    localparam logic [9:0] KEY_A = 10'b1010000010;
    localparam logic [7:0] PT_A  = 8'b10010111;
    localparam logic [7:0] CT_A  = 8'b00111000;

    logic       i_clk   = 1'b0;
    logic       i_rst_n = 1'b1;
    logic       i_valid = 1'b0;
    logic       i_mode  = 1'b0;
    logic       i_ready = 1'b1;
    logic [9:0] i_key   = '0;
    logic [7:0] i_data  = '0;
    logic       o_ready;
    logic       o_valid;
    logic [7:0] o_data;

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    sdes_core dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_mode  (i_mode),
        .i_key   (i_key),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Called just after a falling edge; returns at the falling edge after the accept edge.
    task automatic sendBlock(input logic mode, input logic [9:0] key, input logic [7:0] data);
        int waited = 0;
        i_valid = 1'b1;
        i_mode  = mode;
        i_key   = key;
        i_data  = data;
        while (!o_ready && waited < 20) begin
            @(negedge i_clk);
            waited++;
        end
        checkOutput("accept_ready", 32'(o_ready), 32'd1);
        @(negedge i_clk);
        i_valid = 1'b0;
        i_mode  = ~mode;
        i_key   = ~key;
        i_data  = ~data;
    endtask

    task automatic waitResult(output int latency);
        latency = 0;
        while (!o_valid && latency < 20) begin
            @(negedge i_clk);
            latency++;
        end
    endtask

    task automatic transact(input logic mode, input logic [9:0] key, input logic [7:0] data,
                            output logic [7:0] result, output int latency);
        i_ready = 1'b1;
        sendBlock(mode, key, data);
        waitResult(latency);
        result = o_data;
        @(negedge i_clk);
    endtask

    task automatic applyStimulus(input string tag, input logic mode, input logic [9:0] key,
                                 input logic [7:0] data, input logic [7:0] expected);
        logic [7:0] result;
        int         latency;
        transact(mode, key, data, result, latency);
        checkOutput({tag, "_latency"}, 32'(latency), 32'd3);
        checkOutput({tag, "_data"}, 32'(result), 32'(expected));
        checkOutput({tag, "_valid_drop"}, 32'(o_valid), 32'd0);
        checkOutput({tag, "_ready_back"}, 32'(o_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] ct;
        logic [7:0] pt;
        int         lat;
        int         acc_at [2];
        int         n_acc;
        int         n_res;

        #2;
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        checkOutput("reset_valid", 32'(o_valid), 32'd0);
        checkOutput("reset_data", 32'(o_data), 32'd0);
        checkOutput("reset_ready", 32'(o_ready), 32'd1);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        $display("[TB] directed vectors");
        applyStimulus("enc_a", 1'b0, KEY_A, PT_A, CT_A);
        applyStimulus("dec_a", 1'b1, KEY_A, CT_A, PT_A);
        applyStimulus("enc_zero", 1'b0, 10'h000, 8'h00, 8'hF0);
        applyStimulus("enc_ff", 1'b0, 10'h000, 8'hFF, 8'h14);
        applyStimulus("enc_keyones", 1'b0, 10'h3FF, 8'h00, 8'hEB);
        applyStimulus("dec_zero", 1'b1, 10'h000, 8'hF0, 8'h00);
        applyStimulus("dec_ff", 1'b1, 10'h000, 8'h14, 8'hFF);
        applyStimulus("dec_keyones", 1'b1, 10'h3FF, 8'hEB, 8'h00);

        $display("[TB] backpressure");
        i_ready = 1'b0;
        sendBlock(1'b0, KEY_A, PT_A);
        waitResult(lat);
        checkOutput("bp_latency", 32'(lat), 32'd3);
        for (int c = 0; c < 10; c++) begin
            i_valid = ~i_valid;
            i_data  = 8'(c * 29 + 3);
            @(negedge i_clk);
            checkOutput("bp_valid", 32'(o_valid), 32'd1);
            checkOutput("bp_data", 32'(o_data), 32'(CT_A));
            checkOutput("bp_ready", 32'(o_ready), 32'd0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge i_clk);
        checkOutput("bp_release_valid", 32'(o_valid), 32'd0);
        checkOutput("bp_release_ready", 32'(o_ready), 32'd1);

        $display("[TB] reset during round 1");
        sendBlock(1'b0, 10'h000, 8'h00);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", 32'(o_valid), 32'd0);
        checkOutput("midrst_data", 32'(o_data), 32'd0);
        checkOutput("midrst_ready", 32'(o_ready), 32'd1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (4) @(negedge i_clk);
        checkOutput("midrst_discarded", 32'(o_valid), 32'd0);
        applyStimulus("enc_after_rst", 1'b0, KEY_A, PT_A, CT_A);

        $display("[TB] back-to-back");
        acc_at  = '{0, 0};
        n_acc   = 0;
        n_res   = 0;
        i_ready = 1'b1;
        i_mode  = 1'b0;
        i_key   = KEY_A;
        i_data  = PT_A;
        i_valid = 1'b1;
        for (int c = 0; c < 40 && n_res < 2; c++) begin
            if (o_valid) begin
                n_res++;
                if (n_res == 1) begin
                    checkOutput("b2b_first", 32'(o_data), 32'(CT_A));
                end else begin
                    checkOutput("b2b_second", 32'(o_data), 32'hF0);
                end
            end
            if (o_ready && n_acc < 2) begin
                acc_at[n_acc] = c;
                n_acc++;
            end
            @(negedge i_clk);
            if (n_acc == 1) begin
                i_key  = 10'h000;
                i_data = 8'h00;
            end
        end
        i_valid = 1'b0;
        checkOutput("b2b_accepts", 32'(n_acc), 32'd2);
        checkOutput("b2b_results", 32'(n_res), 32'd2);
        checkOutput("b2b_spacing", 32'(acc_at[1] - acc_at[0]), 32'd5);

        $display("[TB] decrypt(encrypt(x)) sweep");
        for (int x = 0; x < 256; x++) begin
            transact(1'b0, 10'(x * 37 + 11), 8'(x), ct, lat);
            transact(1'b1, 10'(x * 37 + 11), ct, pt, lat);
            checkOutput($sformatf("roundtrip_%0d", x), 32'(pt), 32'(x));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
